// File: rtl/sel_debounce_stepper_if.sv
// Button/select bundle between the board buttons and the select stepper.
// Ports (signals):
//   btn_next, btn_prev : raw active-high buttons (asynchronous to clk)
//   Sel                : registered select index to the 4:1 mux
//   sel_changed        : one-cycle strobe, high in the cycle Sel takes a new value
//   auto_scan          : level request for automatic cycling (only with SEL_AUTO_SCAN_EN)
// Modports: master = button/stimulus side, slave = stepper side.
interface sel_debounce_stepper_if #(
   parameter int unsigned WIDTH = 2
);
   logic             btn_next;
   logic             btn_prev;
   logic [WIDTH-1:0] Sel;
   logic             sel_changed;
`ifdef SEL_AUTO_SCAN_EN
   logic             auto_scan;

   modport master (output btn_next, output btn_prev, output auto_scan,
                   input  Sel,      input  sel_changed);
   modport slave  (input  btn_next, input  btn_prev, input  auto_scan,
                   output Sel,      output sel_changed);
`else
   modport master (output btn_next, output btn_prev,
                   input  Sel,      input  sel_changed);
   modport slave  (input  btn_next, input  btn_prev,
                   output Sel,      output sel_changed);
`endif
endinterface

// File: rtl/sel_debounce_stepper.sv
// Select generator for the board's switch multiplexer: synchronises and
// debounces two raw push-buttons (next/prev) and steps a registered Sel index
// up/down with wrap-around inside 0..NUM_INPUTS-1. sel_changed pulses for one
// cycle whenever Sel takes a new value.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low clear
//   bus   : sel_debounce_stepper_if.slave (btn_next, btn_prev in; Sel, sel_changed out)
// Optional feature macro SEL_AUTO_SCAN_EN: adds SCAN_CYCLES and bus.auto_scan;
// while the synchronised auto_scan is high Sel advances every SCAN_CYCLES
// cycles and button events are ignored.
module sel_debounce_stepper #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned NUM_INPUTS      = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_WIDTH       = 20
`ifdef SEL_AUTO_SCAN_EN
   ,
   parameter int unsigned SCAN_CYCLES     = 50000000
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sel_debounce_stepper_if.slave  bus
);

   localparam int unsigned NUM_BTN  = 2;
   localparam int unsigned BTN_NEXT = 0;
   localparam int unsigned BTN_PREV = 1;

   localparam logic [WIDTH-1:0]     SEL_MAX  = WIDTH'(NUM_INPUTS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } dbc_state_e;

   logic [NUM_BTN-1:0]   btn_raw_c;
   logic [NUM_BTN-1:0]   sync1_q;
   logic [NUM_BTN-1:0]   sync2_q;
   logic [NUM_BTN-1:0]   level_q;
   logic [NUM_BTN-1:0]   level_prev_q;
   logic [NUM_BTN-1:0]   press_c;
   dbc_state_e           state_q [NUM_BTN];
   logic [CNT_WIDTH-1:0] cnt_q   [NUM_BTN];

   logic [WIDTH-1:0]     sel_q;
   logic [WIDTH-1:0]     sel_d;
   logic                 changed_q;
   logic                 changed_d;

   // Wrap helpers; out-of-range values (NUM_INPUTS < 2**WIDTH) fold back into range.
   function automatic logic [WIDTH-1:0] sel_inc(input logic [WIDTH-1:0] s);
      return (s >= SEL_MAX) ? '0 : s + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] sel_dec(input logic [WIDTH-1:0] s);
      return ((s == '0) || (s > SEL_MAX)) ? SEL_MAX : s - WIDTH'(1);
   endfunction

   assign btn_raw_c[BTN_NEXT] = bus.btn_next;
   assign btn_raw_c[BTN_PREV] = bus.btn_prev;

   // Two-flop synchronisers, nothing between the stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw_c;
         sync2_q <= sync1_q;
      end
   end

   // Per-button debounce FSM: a level change is accepted only after the
   // synchronised input has differed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < int'(NUM_BTN); b++) begin
            state_q[b] <= ST_STABLE;
            cnt_q[b]   <= '0;
         end
         level_q <= '0;
      end else begin
         for (int b = 0; b < int'(NUM_BTN); b++) begin
            unique case (state_q[b])
               ST_STABLE: begin
                  if (sync2_q[b] != level_q[b]) begin
                     if (DEBOUNCE_CYCLES <= 1) begin
                        level_q[b] <= ~level_q[b];
                     end else begin
                        state_q[b] <= ST_COUNT;
                        cnt_q[b]   <= CNT_WIDTH'(1);
                     end
                  end
               end
               ST_COUNT: begin
                  if (sync2_q[b] == level_q[b]) begin
                     state_q[b] <= ST_STABLE;
                     cnt_q[b]   <= '0;
                  end else if (cnt_q[b] == CNT_LAST) begin
                     // This edge is the DEBOUNCE_CYCLES-th differing cycle.
                     level_q[b] <= ~level_q[b];
                     state_q[b] <= ST_STABLE;
                     cnt_q[b]   <= '0;
                  end else begin
                     cnt_q[b] <= cnt_q[b] + CNT_WIDTH'(1);
                  end
               end
               default: begin
                  state_q[b] <= ST_STABLE;
                  cnt_q[b]   <= '0;
               end
            endcase
         end
      end
   end

   // Press = debounced rising edge; releases and held levels produce nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev_q <= '0;
      end else begin
         level_prev_q <= level_q;
      end
   end

   assign press_c = level_q & ~level_prev_q;

`ifdef SEL_AUTO_SCAN_EN
   localparam int unsigned      SCAN_W    = $clog2(SCAN_CYCLES) + 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

   logic              scan_sync1_q;
   logic              scan_sync2_q;
   logic [SCAN_W-1:0] scan_cnt_q;
   logic              scan_hit_c;

   // auto_scan synchroniser and period counter; counter idles at 0 while off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_sync1_q <= 1'b0;
         scan_sync2_q <= 1'b0;
         scan_cnt_q   <= '0;
      end else begin
         scan_sync1_q <= bus.auto_scan;
         scan_sync2_q <= scan_sync1_q;
         if (!scan_sync2_q || scan_hit_c) begin
            scan_cnt_q <= '0;
         end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
         end
      end
   end

   assign scan_hit_c = scan_sync2_q && (scan_cnt_q == SCAN_LAST);
`endif

   // Next select value; simultaneous next+prev cancel out.
   always_comb begin
      sel_d     = sel_q;
      changed_d = 1'b0;
`ifdef SEL_AUTO_SCAN_EN
      if (scan_sync2_q) begin
         if (scan_hit_c) begin
            sel_d     = sel_inc(sel_q);
            changed_d = 1'b1;
         end
      end else begin
`endif
         unique case (press_c)
            2'b01: begin
               sel_d     = sel_inc(sel_q);
               changed_d = 1'b1;
            end
            2'b10: begin
               sel_d     = sel_dec(sel_q);
               changed_d = 1'b1;
            end
            default: begin
               sel_d     = sel_q;
               changed_d = 1'b0;
            end
         endcase
`ifdef SEL_AUTO_SCAN_EN
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         changed_q <= changed_d;
      end
   end

   assign bus.Sel         = sel_q;
   assign bus.sel_changed = changed_q;

endmodule

// File: doc/sel_debounce_stepper.md
Name: sel_debounce_stepper

Overview:
Upstream select generator for the board's 4:1 switch multiplexer. It takes two raw, bouncy push-buttons (next/prev), synchronises and debounces each one, and steps a registered Sel index up or down with wrap-around. Sel drives the multiplexer's select input directly. A one-cycle strobe marks every Sel change so downstream display logic can refresh.

Parameters:
WIDTH, 2, width of Sel; must satisfy 2**WIDTH >= NUM_INPUTS
NUM_INPUTS, 4, number of selectable mux inputs; Sel range is 0..NUM_INPUTS-1
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz)
CNT_WIDTH, 20, debounce counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_next  input  1  raw button, active-high, asynchronous to clk; press steps Sel up
btn_prev  input  1  raw button, active-high, asynchronous to clk; press steps Sel down
Sel  output  WIDTH  registered select index to the mux
sel_changed  output  1  registered one-cycle strobe, high in the same cycle Sel takes a new value

Behaviour:
- Reset (rst_n low, asynchronous assert): Sel=0, sel_changed=0, all synchroniser flops=0, debounced levels=0, debounce counters=0. Deassertion is taken synchronously by the upstream reset logic; this block's flops only use it as an async clear.
- Synchroniser: each button passes through a 2-flop synchroniser. There is no logic between the two flops.
- Debounce, independent per button, with a 2-state FSM:
  - STABLE: counter=0. If sync != debounced level, move to COUNT with counter=1.
  - COUNT: if sync == debounced level, return to STABLE and clear the counter (the glitch is rejected). Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES, invert the debounced level at that edge and return to STABLE.
- Press event: the debounced level goes 0->1 (edge-detected against its registered previous value). Releases generate no event. A held button gives exactly one event.
- Step rules, registered on the edge after the press event:
  - next only: Sel = (Sel==NUM_INPUTS-1) ? 0 : Sel+1; sel_changed=1
  - prev only: Sel = (Sel==0) ? NUM_INPUTS-1 : Sel-1; sel_changed=1
  - both in the same cycle: Sel unchanged, sel_changed=0
  - neither: Sel holds, sel_changed=0
- Latency: count the first rising edge at which btn_next is sampled high (and stays high) as edge 1. The debounced level flips at edge DEBOUNCE_CYCLES+2. Sel and sel_changed update at edge DEBOUNCE_CYCLES+3. sel_changed drops at the following edge.
- Sel never leaves 0..NUM_INPUTS-1, including when NUM_INPUTS < 2**WIDTH.
- Reset mid-count or mid-press: all state clears immediately. A button still held after reset must be seen as a new press, so it causes one step after the full debounce latency.

Optional Feature:
Macro SEL_AUTO_SCAN_EN.
- Defined:
  - Adds parameter SCAN_CYCLES (default 50000000) and input port auto_scan (1 bit, level, synchronised internally by 2 flops).
  - While the synchronised auto_scan is high, a scan counter advances Sel by +1 with wrap every SCAN_CYCLES cycles, pulsing sel_changed each time. Button events are ignored.
  - The scan counter clears when auto_scan is low and on reset. The first auto step comes SCAN_CYCLES cycles after the synchronised auto_scan rises.
- Not defined: no auto_scan port, no scan counter. Behaviour is exactly as described above.

Test Plan:
1. DEBOUNCE_CYCLES=4. Reset, then hold btn_next high from edge 1 -> Sel 0->1 at edge 7 with sel_changed high for exactly one cycle; no further steps while held.
2. DEBOUNCE_CYCLES=4. Pulse btn_next high for 3 cycles, then low -> no Sel change, sel_changed stays 0 (glitch rejected).
3. Four clean next presses from Sel=0 -> Sel sequence 1,2,3,0 (wrap). One prev press from 0 -> Sel=3.
4. NUM_INPUTS=3, WIDTH=2. Next presses -> Sel 1,2,0; value 3 never appears.
5. btn_next and btn_prev raised on the same edge with equal debounce timing -> Sel unchanged, no strobe.
6. Hold btn_next, assert rst_n low at debounce count 2, release reset with the button still held -> Sel=0 during reset; a single step to 1 occurs DEBOUNCE_CYCLES+3 edges after reset release.
